// File: rtl/and_reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined N-input reduction cell.
package and_reduce_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_NAND = 2'b11
    } and_reduce_mode_e;

    // Number of values remaining after `level` tree levels of ceil-division by fanin.
    function automatic int and_reduce_count(int n, int fanin, int level);
        int cur;
        cur = n;
        for (int i = 0; i < level; i++) begin
            cur = (cur + fanin - 1) / fanin;
        end
        return cur;
    endfunction

    function automatic int and_reduce_stages(int n, int fanin);
        int cur;
        int stages;
        cur    = n;
        stages = 0;
        for (int i = 0; i < 64; i++) begin
            if (cur > 1) begin
                cur    = (cur + fanin - 1) / fanin;
                stages = stages + 1;
            end
        end
        return (stages < 1) ? 1 : stages;
    endfunction

    function automatic logic and_reduce_identity(and_reduce_mode_e mode);
        return (mode == MODE_AND) || (mode == MODE_NAND);
    endfunction

    // NAND combines as AND inside the tree; the inversion happens once at the output.
    function automatic logic and_reduce_op(and_reduce_mode_e mode, logic a, logic b);
        logic r;
        case (mode)
            MODE_AND:  r = a & b;
            MODE_OR:   r = a | b;
            MODE_XOR:  r = a ^ b;
            MODE_NAND: r = a & b;
            default:   r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/and_reduce_stage.sv
// One level of the reduction tree: combine groups of FANIN values, pad partial
// groups with the mode's identity, and register data/mode/valid with local flow control.
module and_reduce_stage
    import and_reduce_pkg::*;
#(
    parameter int N_VAL = 3,
    parameter int WIDTH = 1,
    parameter int FANIN = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [N_VAL*WIDTH-1:0]                        up_data,
    input  and_reduce_mode_e                              up_mode,
    input  logic                                          up_valid,
    output logic                                          up_ready,
    output logic [((N_VAL+FANIN-1)/FANIN)*WIDTH-1:0]      dn_data,
    output and_reduce_mode_e                              dn_mode,
    output logic                                          dn_valid,
    input  logic                                          dn_ready
);

    localparam int N_OUT = (N_VAL + FANIN - 1) / FANIN;
    localparam int N_PAD = N_OUT * FANIN;

    logic                     ident;
    logic                     acc;
    logic [N_PAD*WIDTH-1:0]   padded;
    logic [N_OUT*WIDTH-1:0]   combined;

    always_comb begin
        ident    = and_reduce_identity(up_mode);
        acc      = 1'b0;
        padded   = {(N_PAD*WIDTH){ident}};
        padded[N_VAL*WIDTH-1:0] = up_data;
        combined = '0;
        for (int g = 0; g < N_OUT; g++) begin
            for (int b = 0; b < WIDTH; b++) begin
                acc = ident;
                for (int j = 0; j < FANIN; j++) begin
                    acc = and_reduce_op(up_mode, acc, padded[(g*FANIN + j)*WIDTH + b]);
                end
                combined[g*WIDTH + b] = acc;
            end
        end
    end

    // An empty register always accepts, so bubbles collapse toward the output.
    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
            dn_mode  <= MODE_AND;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= combined;
                dn_mode <= up_mode;
            end
        end
    end

endmodule

// File: rtl/and_reduce_pipe.sv
// Pipelined N-input bitwise reduction (AND/OR/XOR/NAND) with valid/ready on both sides.
// Define AND_REDUCE_QN_EN to add the complementary QN output.
module and_reduce_pipe
    import and_reduce_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int WIDTH = 1,
    parameter int FANIN = 4
) (
    input  logic                    CLK,
    input  logic                    RSTB,
    input  logic [N_IN*WIDTH-1:0]   IN,
    input  logic [1:0]              MODE,
    input  logic                    IVLD,
    output logic                    IRDY,
    output logic [WIDTH-1:0]        Q,
    output logic                    OVLD,
    input  logic                    ORDY
`ifdef AND_REDUCE_QN_EN
    ,
    output logic [WIDTH-1:0]        QN
`endif
);

    localparam int STAGES = and_reduce_stages(N_IN, FANIN);

    logic [STAGES:0]  link_valid;
    logic [STAGES:0]  link_ready;
    and_reduce_mode_e link_mode [STAGES+1];
    logic [WIDTH-1:0] last_data;

    assign link_valid[0]      = IVLD;
    assign link_mode[0]       = and_reduce_mode_e'(MODE);
    assign link_ready[STAGES] = ORDY;
    assign IRDY               = link_ready[0];

    for (genvar s = 0; s < STAGES; s++) begin : stage_g
        localparam int NV = and_reduce_count(N_IN, FANIN, s);
        localparam int NO = and_reduce_count(N_IN, FANIN, s + 1);

        logic [NV*WIDTH-1:0] feed;
        logic [NO*WIDTH-1:0] data;

        if (s == 0) begin : g_first
            assign feed = IN;
        end else begin : g_next
            assign feed = stage_g[s-1].data;
        end

        and_reduce_stage #(
            .N_VAL (NV),
            .WIDTH (WIDTH),
            .FANIN (FANIN)
        ) u_stage (
            .clk      (CLK),
            .rst_n    (RSTB),
            .up_data  (feed),
            .up_mode  (link_mode[s]),
            .up_valid (link_valid[s]),
            .up_ready (link_ready[s]),
            .dn_data  (data),
            .dn_mode  (link_mode[s+1]),
            .dn_valid (link_valid[s+1]),
            .dn_ready (link_ready[s+1])
        );
    end

    assign last_data = stage_g[STAGES-1].data;
    assign OVLD      = link_valid[STAGES];
    assign Q         = (link_mode[STAGES] == MODE_NAND) ? ~last_data : last_data;

`ifdef AND_REDUCE_QN_EN
    assign QN = ~Q;
`endif

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Directed bench for and_reduce_pipe: three parameterisations driven from one vector table
// plus hand-written backpressure and mid-flight reset sequences.
module tb_and_reduce_pipe;
    import and_reduce_pkg::*;

    logic clk;
    logic rstb;

    logic [2:0]  a_in;
    logic [1:0]  a_mode;
    logic        a_ivld, a_irdy, a_q, a_ovld, a_ordy;
    logic [31:0] b_in;
    logic [1:0]  b_mode;
    logic        b_ivld, b_irdy, b_ovld, b_ordy;
    logic [3:0]  b_q;
    logic [4:0]  c_in;
    logic [1:0]  c_mode;
    logic        c_ivld, c_irdy, c_q, c_ovld, c_ordy;
`ifdef AND_REDUCE_QN_EN
    logic        a_qn;
    logic [3:0]  b_qn;
    logic        c_qn;
`endif

    int n_cmp;
    int n_bad;

    typedef struct {
        int          sel;
        logic [31:0] din;
        logic [1:0]  mode;
        logic [3:0]  q;
    } vec_t;

    vec_t vecs[$];
    int   lat [3] = '{1, 3, 2};
    logic [3:0] mask [3] = '{4'h1, 4'hF, 4'h1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    and_reduce_pipe #(.N_IN(3), .WIDTH(1), .FANIN(4)) dut_a (
        .CLK(clk), .RSTB(rstb), .IN(a_in), .MODE(a_mode), .IVLD(a_ivld), .IRDY(a_irdy),
        .Q(a_q), .OVLD(a_ovld), .ORDY(a_ordy)
`ifdef AND_REDUCE_QN_EN
        , .QN(a_qn)
`endif
    );

    and_reduce_pipe #(.N_IN(8), .WIDTH(4), .FANIN(2)) dut_b (
        .CLK(clk), .RSTB(rstb), .IN(b_in), .MODE(b_mode), .IVLD(b_ivld), .IRDY(b_irdy),
        .Q(b_q), .OVLD(b_ovld), .ORDY(b_ordy)
`ifdef AND_REDUCE_QN_EN
        , .QN(b_qn)
`endif
    );

    and_reduce_pipe #(.N_IN(5), .WIDTH(1), .FANIN(4)) dut_c (
        .CLK(clk), .RSTB(rstb), .IN(c_in), .MODE(c_mode), .IVLD(c_ivld), .IRDY(c_irdy),
        .Q(c_q), .OVLD(c_ovld), .ORDY(c_ordy)
`ifdef AND_REDUCE_QN_EN
        , .QN(c_qn)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(int sel, logic [31:0] din, logic [1:0] mode, logic [3:0] q);
        vec_t v;
        v.sel  = sel;
        v.din  = din;
        v.mode = mode;
        v.q    = q;
        return v;
    endfunction

    task automatic drive(input int sel, input logic [31:0] din, input logic [1:0] mode, input logic vld);
        case (sel)
            0:       begin a_in = din[2:0]; a_mode = mode; a_ivld = vld; end
            1:       begin b_in = din;      b_mode = mode; b_ivld = vld; end
            default: begin c_in = din[4:0]; c_mode = mode; c_ivld = vld; end
        endcase
    endtask

    function automatic logic [3:0] get_q(int sel);
        case (sel)
            0:       return {3'b0, a_q};
            1:       return b_q;
            default: return {3'b0, c_q};
        endcase
    endfunction

    function automatic logic get_ovld(int sel);
        case (sel)
            0:       return a_ovld;
            1:       return b_ovld;
            default: return c_ovld;
        endcase
    endfunction

    function automatic logic get_irdy(int sel);
        case (sel)
            0:       return a_irdy;
            1:       return b_irdy;
            default: return c_irdy;
        endcase
    endfunction

    task automatic check_qn(input string name, input int sel, input logic [3:0] exp_q);
`ifdef AND_REDUCE_QN_EN
        logic [3:0] qn;
        case (sel)
            0:       qn = {3'b0, a_qn};
            1:       qn = b_qn;
            default: qn = {3'b0, c_qn};
        endcase
        check(name, 32'(qn), 32'(~exp_q & mask[sel]));
`endif
    endtask

    // Called on a falling edge: one transfer, then the output is checked exactly lat cycles later.
    task automatic apply_stimulus(input string name, input int sel, input logic [31:0] din,
                                  input logic [1:0] mode, input logic [3:0] exp_q);
        drive(sel, din, mode, 1'b1);
        #1;
        check({name, "_irdy"}, 32'(get_irdy(sel)), 32'd1);
        @(negedge clk);
        drive(sel, 32'h0, mode, 1'b0);
        for (int k = 1; k < lat[sel]; k++) begin
            check({name, "_early"}, 32'(get_ovld(sel)), 32'd0);
            @(negedge clk);
        end
        check({name, "_ovld"}, 32'(get_ovld(sel)), 32'd1);
        check({name, "_q"}, 32'(get_q(sel)), 32'(exp_q));
        check_qn({name, "_qn"}, sel, exp_q);
    endtask

    task automatic check_reset_state(input string name);
        for (int s = 0; s < 3; s++) begin
            check($sformatf("%s_ovld%0d", name, s), 32'(get_ovld(s)), 32'd0);
            check($sformatf("%s_q%0d", name, s), 32'(get_q(s)), 32'd0);
            check_qn($sformatf("%s_qn%0d", name, s), s, 4'h0);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] bp_exp [6];
        int         in_idx;
        int         out_idx;
        logic       saw_irdy_low;

        n_cmp = 0;
        n_bad = 0;

        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 32'(i), MODE_AND, (i == 7) ? 4'h1 : 4'h0));
        vecs.push_back(mk(0, 32'b000, MODE_OR,   4'h0));
        vecs.push_back(mk(0, 32'b100, MODE_OR,   4'h1));
        vecs.push_back(mk(0, 32'b011, MODE_XOR,  4'h0));
        vecs.push_back(mk(0, 32'b111, MODE_XOR,  4'h1));
        vecs.push_back(mk(0, 32'b001, MODE_XOR,  4'h1));
        vecs.push_back(mk(0, 32'b111, MODE_NAND, 4'h0));
        vecs.push_back(mk(0, 32'b110, MODE_NAND, 4'h1));
        vecs.push_back(mk(1, 32'h0000_0010, MODE_OR,   4'h1));
        vecs.push_back(mk(1, 32'hFFFF_FFFF, MODE_AND,  4'hF));
        vecs.push_back(mk(1, 32'hFFFF_FF7F, MODE_AND,  4'h7));
        vecs.push_back(mk(1, 32'h0000_0321, MODE_XOR,  4'h0));
        vecs.push_back(mk(1, 32'h8421_0000, MODE_XOR,  4'hF));
        vecs.push_back(mk(1, 32'hFFFF_FFFF, MODE_NAND, 4'h0));
        vecs.push_back(mk(1, 32'h1111_1111, MODE_NAND, 4'hE));
        vecs.push_back(mk(1, 32'h0000_0000, MODE_OR,   4'h0));
        vecs.push_back(mk(2, 32'b00111, MODE_XOR,  4'h1));
        vecs.push_back(mk(2, 32'b11111, MODE_NAND, 4'h0));
        vecs.push_back(mk(2, 32'b11111, MODE_AND,  4'h1));
        vecs.push_back(mk(2, 32'b01111, MODE_AND,  4'h0));
        vecs.push_back(mk(2, 32'b10000, MODE_OR,   4'h1));
        vecs.push_back(mk(2, 32'b10000, MODE_XOR,  4'h1));
        vecs.push_back(mk(2, 32'b11000, MODE_XOR,  4'h0));

        rstb = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 32'h0, MODE_AND, 1'b0);
        a_ordy = 1'b1;
        b_ordy = 1'b1;
        c_ordy = 1'b1;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rstb = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) check($sformatf("post_reset_irdy%0d", s), 32'(get_irdy(s)), 32'd1);
        @(negedge clk);

        foreach (vecs[i]) begin
            apply_stimulus($sformatf("vec%0d", i), vecs[i].sel, vecs[i].din, vecs[i].mode, vecs[i].q);
        end
        @(negedge clk);
        @(negedge clk);

        // Six back-to-back transfers into the 3-stage instance while the sink stalls in cycles 2-5.
        for (int i = 0; i < 6; i++) bp_exp[i] = 4'(i + 1);
        in_idx       = 0;
        out_idx      = 0;
        saw_irdy_low = 1'b0;
        for (int c = 0; c < 40; c++) begin
            b_ordy = !(c >= 2 && c <= 5);
            if (in_idx < 6) drive(1, {28'h0, bp_exp[in_idx]}, MODE_OR, 1'b1);
            else            drive(1, 32'h0, MODE_OR, 1'b0);
            #1;
            if (!b_irdy) saw_irdy_low = 1'b1;
            if (c == 3) check("bp_full_irdy", 32'(b_irdy), 32'd0);
            if (c >= 3 && c <= 5) check($sformatf("bp_stall_ovld_c%0d", c), 32'(b_ovld), 32'd1);
            if (b_ovld) begin
                if (out_idx < 6) begin
                    check($sformatf("bp_q_c%0d", c), 32'(b_q), 32'(bp_exp[out_idx]));
                    check_qn($sformatf("bp_qn_c%0d", c), 1, bp_exp[out_idx]);
                end else begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL bp_extra_output: got output #%0d, expected only 6", out_idx + 1);
                end
                if (b_ordy) out_idx++;
            end
            if (b_ivld && b_irdy) in_idx++;
            @(negedge clk);
        end
        check("bp_in_count", 32'(in_idx), 32'd6);
        check("bp_out_count", 32'(out_idx), 32'd6);
        check("bp_irdy_dropped", 32'(saw_irdy_low), 32'd1);

        // Two transfers in flight, the oldest already at the output, then an async reset pulse.
        b_ordy = 1'b0;
        drive(1, 32'h0000_000F, MODE_OR, 1'b1);
        @(negedge clk);
        drive(1, 32'h0000_0003, MODE_OR, 1'b1);
        @(negedge clk);
        drive(1, 32'h0, MODE_OR, 1'b0);
        @(negedge clk);
        #1;
        check("rst_pre_ovld", 32'(b_ovld), 32'd1);
        check("rst_pre_q", 32'(b_q), 32'hF);
        #1;
        rstb = 1'b0;
        #1;
        check_reset_state("rst_mid");
        @(negedge clk);
        rstb   = 1'b1;
        b_ordy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rst_no_stale_%0d", k), 32'(b_ovld), 32'd0);
            @(negedge clk);
        end
        apply_stimulus("rst_after", 1, 32'h0000_0500, MODE_OR, 4'h5);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/and_reduce_pipe.md
# and_reduce_pipe

Parametrised, pipelined N-input logic-reduction cell: the successor to the fixed 3-input AND gate model. It reduces `N_IN` operands of `WIDTH` bits each, bitwise, under a per-transfer mode (AND, OR, XOR, NAND). A registered reduction tree carries the result, with a valid/ready handshake on both sides. It sits in the cell-model library as a timing-annotatable building block for datapath and power-characterisation benches.

## Interface
Parameters:
- `N_IN`, 3: number of operands, ≥1.
- `WIDTH`, 1: bits per operand and result, ≥1.
- `FANIN`, 4: operands combined per tree node per stage, ≥2.
- `STAGES`, derived, not overridable: ceil(log_FANIN(N_IN)), minimum 1.

Ports:
- `CLK`, in, 1: clock, rising edge.
- `RSTB`, in, 1: asynchronous, active-low reset.
- `IN`, in, N_IN*WIDTH: operands; operand k occupies bits [k*WIDTH +: WIDTH].
- `MODE`, in, 2: 00 AND, 01 OR, 10 XOR, 11 NAND; sampled with `IN`.
- `IVLD`, in, 1: input transfer valid.
- `IRDY`, out, 1: input ready.
- `Q`, out, WIDTH: reduction result.
- `OVLD`, out, 1: `Q` valid.
- `ORDY`, in, 1: downstream ready.
- `QN`, out, WIDTH: complement of `Q`; present only with `AND_REDUCE_QN_EN`.

## Operation
- A transfer occurs when `IVLD` and `IRDY` are both high on a `CLK` edge. Output hands off when `OVLD` and `ORDY` are both high.
- Each stage combines groups of up to `FANIN` values bitwise using the stage's mode, then registers the result together with the mode and a valid bit.
- Partial groups are padded with the identity element: 1 for AND and NAND, 0 for OR and XOR.
- NAND reduces as AND through the tree. Inversion is applied only at the final output, so `Q` is the complement of the AND of all operands.
- Stage s advances when its register is empty or stage s+1 advances. The last stage advances on `ORDY`. Bubbles collapse.
- `IRDY` is combinational: stage-0 register empty, or stage 0 advancing.
- `Q`, `MODE` and `OVLD` are held stable while `OVLD && !ORDY`.
- `N_IN`=1: the result is the operand itself, or its complement for NAND, after one stage.
- XOR for multi-bit operands is bitwise parity across operands, per bit position.

## Timing
- Reset (`RSTB` low, asynchronous): all stage valid bits 0, `OVLD`=0, `Q`=0, `QN`=all ones, stored mode=00. `IRDY`=1 once `RSTB` is high.
- Reset asserted mid-operation discards all in-flight data. The first post-reset transfer emerges after `STAGES` cycles.
- Latency with no backpressure: exactly `STAGES` cycles from accepting edge to `OVLD` high.
- Throughput: one transfer per cycle when `ORDY` is held high.
- Simultaneous input accept and output drain on a full pipe: both happen and the occupancy is unchanged.
- Full pipe with `ORDY` low: `IRDY` low. Already-captured data is never overwritten.

## Configuration
- `AND_REDUCE_QN_EN` defined: `QN` port exists and equals ~`Q` at all times, including reset (all ones).
- Not defined: `QN` port and its logic are absent. All other behaviour is identical.

## Structure
- Package `and_reduce_pkg` holds:
  - Mode enum `and_reduce_mode_e` (AND, OR, XOR, NAND).
  - Function `and_reduce_stages(n, fanin)`.
  - Function `and_reduce_identity(mode)`.
  - Function `and_reduce_op(mode, a, b)`.
- Sub-module `and_reduce_stage`: one tree level. It does the combine, padding, and registers data, mode and valid with local advance logic. It is instantiated `STAGES` times with generate.

## Test plan
- Default parameters, AND mode, all 8 input combinations of 1-bit operands: `Q`=1 only for `IN`=3'b111, one cycle after accept.
- `N_IN`=8, `WIDTH`=4, `FANIN`=2, OR mode, `IN`=32'h0000_0010: `Q`=4'h1 with `OVLD` exactly 3 cycles after accept.
- `N_IN`=5, `FANIN`=4, XOR mode, operands 1,1,1,0,0 (WIDTH 1): `Q`=1. Then NAND of all ones: `Q`=0.
- Back-to-back stream of 6 transfers with `ORDY` low for cycles 2–5: no loss or duplication, output order preserved, `IRDY` drops when full, `Q` held stable while stalled.
- `RSTB` pulsed low with 2 transfers in flight: `OVLD`=0 and `Q`=0 immediately. No stale result appears afterwards.
- With `AND_REDUCE_QN_EN`: `QN`=~`Q` on every cycle, and `QN`=all ones during reset.
